// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the uart TX arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int ARB_IDLE_CNT_W = 16;
  localparam int UART_BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  // Scan from the farthest offset down so the nearest candidate to ptr wins.
  always_comb begin
    int          j;
    logic [IDW-1:0] jdx;
    any = 1'b0;
    idx = '0;
    j   = 0;
    jdx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j   = (int'(ptr) + i) % NREQ;
      jdx = IDW'(j);
      if (req[jdx]) begin
        any = 1'b1;
        idx = jdx;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter sharing the uart TX FIFO between NREQ byte streams.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int                        NREQ    = 4,
  parameter logic [ARB_IDLE_CNT_W-1:0] TIMEOUT = 16'd1000,
  localparam int                       IDW     = $clog2(NREQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*UART_BYTE_W-1:0]   req_data,
  input  logic [NREQ-1:0]               req_last,
  output logic [NREQ-1:0]               req_ready,
  output logic                          uart_tx_start,
  output logic [UART_BYTE_W-1:0]        uart_tx_data_in,
  input  logic                          uart_tx_fifo_full,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic                          timeout_evt
);

  arb_state_e                state_q, state_d;
  logic [IDW-1:0]            owner_q, owner_d;
  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [ARB_IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                      start_q, start_d;
  logic [UART_BYTE_W-1:0]    data_q, data_d;
  logic                      last_q, last_d;
  logic                      tmo_q, tmo_d;
  logic                      busy_q, busy_d;

  logic                      pick_any_s;
  logic [IDW-1:0]            pick_idx_s;
  logic                      owner_valid_s;
  logic                      owner_last_s;
  logic [UART_BYTE_W-1:0]    owner_byte_s;
  logic                      accept_s;
  logic [IDW-1:0]            next_owner_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  assign owner_valid_s = req_valid[owner_q];
  assign owner_last_s  = req_last[owner_q];
  assign owner_byte_s  = req_data[int'(owner_q)*UART_BYTE_W +: UART_BYTE_W];
  assign accept_s      = (state_q == LOCK) && owner_valid_s && !uart_tx_fifo_full;
  assign next_owner_s  = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // Only the owner may see ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if ((state_q == LOCK) && !uart_tx_fifo_full) begin
      req_ready[owner_q] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic; start and timeout are single-cycle pulses by default.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    start_d    = 1'b0;
    data_d     = data_q;
    last_d     = last_q;
    tmo_d      = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          owner_d    = pick_idx_s;
          busy_d     = 1'b1;
          idle_cnt_d = '0;
          state_d    = LOCK;
        end else begin
          busy_d = 1'b0;
        end
      end
      LOCK: begin
        if (accept_s) begin
          data_d     = owner_byte_s;
          start_d    = 1'b1;
          last_d     = owner_last_s;
          idle_cnt_d = '0;
          state_d    = GAP;
        end else if (!owner_valid_s) begin
          if ((TIMEOUT != 16'd0) && (idle_cnt_q == TIMEOUT - 16'd1)) begin
            tmo_d    = 1'b1;
            busy_d   = 1'b0;
            rr_ptr_d = next_owner_s;
            state_d  = IDLE;
          end else if (idle_cnt_q != {ARB_IDLE_CNT_W{1'b1}}) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end else begin
            idle_cnt_d = idle_cnt_q;
          end
        end else begin
          // Backpressure stall: the owner is still talking, so do not age it.
          idle_cnt_d = idle_cnt_q;
        end
      end
      GAP: begin
        if (last_q) begin
          busy_d   = 1'b0;
          rr_ptr_d = next_owner_s;
          state_d  = IDLE;
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      start_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      tmo_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      start_q    <= start_d;
      data_q     <= data_d;
      last_q     <= last_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_tx_start   = start_q;
  assign uart_tx_data_in = data_q;
  assign grant_id        = owner_q;
  assign busy            = busy_q;
  assign timeout_evt     = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester byte queues, message-level round-robin model, directed and random traffic.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              fifo_full;
  logic [1:0]        grant_id;
  logic              busy;
  logic              tmo;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [8:0]      txq [NREQ][$];
  logic [9:0]      expq[$];
  int              pulse_cyc[$];
  int              tmo_cyc[$];
  logic [NREQ-1:0] acc_vec;
  logic            full_rand;
  logic            full_force;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(16'd8)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .uart_tx_start     (tx_start),
    .uart_tx_data_in   (tx_data),
    .uart_tx_fifo_full (fifo_full),
    .grant_id          (grant_id),
    .busy              (busy),
    .timeout_evt       (tmo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    fifo_full = full_rand ? ($urandom_range(0, 2) == 0) : full_force;
    for (int i = 0; i < NREQ; i++) begin
      if (txq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = txq[i][0][7:0];
        req_last[i]         = txq[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
  endtask

  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++)
      if (acc_vec[i]) void'(txq[i].pop_front());
    check_eq("start_follows_accept", 32'(tx_start), 32'(|acc_vec));
    if (tx_start) begin
      pulse_cyc.push_back(cyc);
      check_eq("pulse_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check_eq("tx_data", 32'(tx_data), 32'(e[7:0]));
        check_eq("tx_owner", 32'(grant_id), 32'(e[9:8]));
      end
    end
    if (tmo) tmo_cyc.push_back(cyc);
    drive_inputs();
    #1;
    acc_vec = req_valid & req_ready;
    check_eq("ready_legal", 32'($countones(req_ready) <= (fifo_full ? 0 : 1)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) txq[i].delete();
    expq.delete();
    pulse_cyc.delete();
    tmo_cyc.delete();
    acc_vec    = '0;
    full_rand  = 1'b0;
    full_force = 1'b0;
    drive_inputs();
    repeat (2) @(negedge clk);
    check_eq("rst_start", 32'(tx_start), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_tmo", 32'(tmo), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
  endtask

  task automatic push_byte(input int id, input logic [7:0] b, input logic last);
    txq[id].push_back({last, b});
  endtask

  // Whole messages queued together: serve one complete message per requester, rotating after each.
  task automatic model_order(input int start_ptr);
    logic [8:0] cp [NREQ][$];
    logic [8:0] b;
    int         ptr;
    int         r;
    int         total;
    logic       done;
    ptr   = start_ptr;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      cp[i] = txq[i];
      total += cp[i].size();
    end
    while (total > 0) begin
      r = 0;
      for (int k = NREQ - 1; k >= 0; k--)
        if (cp[(ptr + k) % NREQ].size() > 0) r = (ptr + k) % NREQ;
      done = 1'b0;
      while (!done && cp[r].size() > 0) begin
        b = cp[r].pop_front();
        total--;
        expq.push_back({2'(r), b[7:0]});
        done = b[8];
      end
      ptr = (r + 1) % NREQ;
    end
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (expq.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int d;
    int n;
    rst = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;

    // Single requester, two bytes, then rr pointer must sit at 1.
    do_reset();
    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h69, 1'b1);
    model_order(0);
    run_drain("t1_drain", 20);
    check_eq("t1_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) check_eq("t1_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd2);
    step();
    check_eq("t1_busy_released", 32'(busy), 32'd0);
    push_byte(0, 8'hA0, 1'b1);
    push_byte(1, 8'hA1, 1'b1);
    model_order(1);
    run_drain("t1_rrptr_drain", 20);

    // Contention between requesters 0 and 2.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_byte(0, 8'($urandom), 1'(k == 2));
      push_byte(2, 8'($urandom), 1'(k == 2));
    end
    model_order(0);
    run_drain("t2_drain", 40);

    // Backpressure for 50 cycles mid-message: no pulses, no timeout.
    do_reset();
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b1);
    model_order(0);
    n = 0;
    while (pulse_cyc.size() < 1 && n < 10) begin
      step();
      n++;
    end
    check_eq("t3_first_pulse", 32'(pulse_cyc.size()), 32'd1);
    full_force = 1'b1;
    repeat (50) step();
    check_eq("t3_no_pulse_while_full", 32'(pulse_cyc.size()), 32'd1);
    check_eq("t3_no_timeout", 32'(tmo_cyc.size()), 32'd0);
    check_eq("t3_busy_held", 32'(busy), 32'd1);
    full_force = 1'b0;
    step();
    d = cyc;
    run_drain("t3_drain", 10);
    if (pulse_cyc.size() == 2) check_eq("t3_resume_latency", 32'(pulse_cyc[1]), 32'(d + 1));
    else check_eq("t3_pulses", 32'(pulse_cyc.size()), 32'd2);

    // Owner goes silent without last; requester 1 waits.
    do_reset();
    push_byte(0, 8'h5A, 1'b0);
    push_byte(1, 8'hC3, 1'b1);
    expq.push_back({2'd0, 8'h5A});
    expq.push_back({2'd1, 8'hC3});
    n = 0;
    while (tmo_cyc.size() == 0 && n < 40) begin
      step();
      n++;
    end
    check_eq("t4_timeout_seen", 32'(tmo_cyc.size()), 32'd1);
    if (tmo_cyc.size() == 1 && pulse_cyc.size() == 1)
      check_eq("t4_timeout_delay", 32'(tmo_cyc[0] - pulse_cyc[0]), 32'd9);
    check_eq("t4_busy_at_tmo", 32'(busy), 32'd0);
    step();
    check_eq("t4_tmo_one_cycle", 32'(tmo), 32'd0);
    check_eq("t4_regrant_busy", 32'(busy), 32'd1);
    check_eq("t4_regrant_id", 32'(grant_id), 32'd1);
    run_drain("t4_drain", 10);

    // Fairness with wrap: all four hold two single-byte messages.
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < NREQ; r++)
        push_byte(r, 8'(8'h30 + 8'(16 * m + r)), 1'b1);
    model_order(0);
    run_drain("t5_drain", 60);
    check_eq("t5_pulses", 32'(pulse_cyc.size()), 32'd8);
    for (int k = 1; k < pulse_cyc.size(); k++)
      check_eq("t5_spacing", 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'd3);

    // Reset the cycle after an accept.
    do_reset();
    push_byte(2, 8'hE1, 1'b0);
    push_byte(2, 8'hE2, 1'b0);
    push_byte(2, 8'hE3, 1'b1);
    n = 0;
    while (acc_vec == '0 && n < 10) begin
      step();
      n++;
    end
    check_eq("t6_accept_seen", 32'(acc_vec != '0), 32'd1);
    @(posedge clk);
    #1;
    check_eq("t6_start_before_rst", 32'(tx_start), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_start", 32'(tx_start), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_grant", 32'(grant_id), 32'd0);
    for (int i = 0; i < NREQ; i++) txq[i].delete();
    expq.delete();
    acc_vec = '0;
    drive_inputs();
    @(negedge clk);
    rst = 1'b1;
    push_byte(1, 8'h71, 1'b1);
    push_byte(3, 8'h73, 1'b1);
    model_order(0);
    run_drain("t6_rearb_drain", 20);

    // Random messages with random FIFO backpressure.
    for (int pass = 0; pass < 3; pass++) begin
      do_reset();
      for (int r = 0; r < NREQ; r++) begin
        int nmsg;
        nmsg = $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), 1'(b == len - 1));
        end
      end
      model_order(0);
      full_rand = 1'b1;
      run_drain("rand_drain", 3000);
      full_rand = 1'b0;
      step();
      check_eq("rand_no_timeout", 32'(tmo_cyc.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

endmodule
